// File: rtl/prbs_checker.sv
// Receive-side PRBS checker: self-synchronises to a serial Fibonacci LFSR stream,
// declares lock, then flags per-bit errors against a free-running local reference.
module prbs_checker #(
    parameter int WIDTH      = 7,
    parameter int LOCK_CNT   = 16,
    parameter int ERR_THRESH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset_b,
    input  logic             enable,
    input  logic             data_in,
    input  logic             clear_errs,
    output logic             locked,
    output logic             bit_error,
    output logic             lost_lock,
    output logic [CNT_W-1:0] err_count
);

    localparam int SW = $clog2(WIDTH + 1);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int RW = $clog2(ERR_THRESH + 1);

    // Feedback taps; bit i set means R[i] contributes to the predicted bit.
    localparam logic [8:0] TAPS9 =
        (WIDTH == 3) ? 9'b000000110 :
        (WIDTH == 4) ? 9'b000001100 :
        (WIDTH == 5) ? 9'b000010100 :
        (WIDTH == 6) ? 9'b000110000 :
        (WIDTH == 7) ? 9'b001100000 :
        (WIDTH == 8) ? 9'b010111000 :
        (WIDTH == 9) ? 9'b100010000 : 9'b000000000;
    localparam logic [WIDTH-1:0] TAPS = TAPS9[WIDTH-1:0];

    localparam logic [SW-1:0]    SEED_LAST  = SW'(WIDTH - 1);
    localparam logic [MW-1:0]    MATCH_LAST = MW'(LOCK_CNT - 1);
    localparam logic [RW-1:0]    RUN_LAST   = RW'(ERR_THRESH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    function automatic logic lfsr_predict(input logic [WIDTH-1:0] r);
        return ^(r & TAPS);
    endfunction

    state_t             state_r;
    state_t             state_n;
    logic [WIDTH-1:0]   shreg_r;
    logic [WIDTH-1:0]   shreg_n;
    logic [SW-1:0]      seed_cnt_r;
    logic [SW-1:0]      seed_cnt_n;
    logic [MW-1:0]      match_cnt_r;
    logic [MW-1:0]      match_cnt_n;
    logic [RW-1:0]      err_run_r;
    logic [RW-1:0]      err_run_n;
    logic [CNT_W-1:0]   err_count_r;
    logic [CNT_W-1:0]   err_count_s;
    logic               locked_r;
    logic               locked_s;
    logic               bit_error_r;
    logic               bit_error_s;
    logic               lost_lock_r;
    logic               lost_lock_s;
    logic               predict_s;
    logic               mismatch_s;
    logic               run_hit_s;
    logic [WIDTH-1:0]   shift_in_s;

    // Shared prediction and comparison terms.
    always_comb begin
        predict_s  = lfsr_predict(shreg_r);
        mismatch_s = data_in ^ predict_s;
        run_hit_s  = (err_run_r == RUN_LAST);
        shift_in_s = {shreg_r[WIDTH-2:0], data_in};
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_b) begin
            state_r <= ST_SEED;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state and datapath next values.
    always_comb begin
        state_n     = state_r;
        shreg_n     = shreg_r;
        seed_cnt_n  = seed_cnt_r;
        match_cnt_n = match_cnt_r;
        err_run_n   = err_run_r;
        if (enable) begin
            case (state_r)
                ST_SEED: begin
                    shreg_n = shift_in_s;
                    if (seed_cnt_r == SEED_LAST) begin
                        seed_cnt_n = {SW{1'b0}};
                        // An all-zero window is the LFSR lockup value: keep seeding.
                        if (shift_in_s != {WIDTH{1'b0}}) begin
                            state_n = ST_VERIFY;
                        end else begin
                            state_n = ST_SEED;
                        end
                    end else begin
                        seed_cnt_n = seed_cnt_r + SW'(1);
                    end
                end
                ST_VERIFY: begin
                    shreg_n = shift_in_s;
                    if (mismatch_s) begin
                        state_n     = ST_SEED;
                        match_cnt_n = {MW{1'b0}};
                        seed_cnt_n  = {SW{1'b0}};
                    end else if (match_cnt_r == MATCH_LAST) begin
                        state_n     = ST_LOCKED;
                        match_cnt_n = {MW{1'b0}};
                    end else begin
                        match_cnt_n = match_cnt_r + MW'(1);
                    end
                end
                ST_LOCKED: begin
                    // Reference self-runs so a received error cannot corrupt it.
                    shreg_n = {shreg_r[WIDTH-2:0], predict_s};
                    if (mismatch_s) begin
                        if (run_hit_s) begin
                            state_n     = ST_SEED;
                            shreg_n     = {WIDTH{1'b0}};
                            seed_cnt_n  = {SW{1'b0}};
                            match_cnt_n = {MW{1'b0}};
                            err_run_n   = {RW{1'b0}};
                        end else begin
                            err_run_n = err_run_r + RW'(1);
                        end
                    end else begin
                        err_run_n = {RW{1'b0}};
                    end
                end
                default: begin
                    state_n     = ST_SEED;
                    shreg_n     = {WIDTH{1'b0}};
                    seed_cnt_n  = {SW{1'b0}};
                    match_cnt_n = {MW{1'b0}};
                    err_run_n   = {RW{1'b0}};
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // Datapath registers.
    always_ff @(posedge clock) begin
        if (!reset_b) begin
            shreg_r     <= {WIDTH{1'b0}};
            seed_cnt_r  <= {SW{1'b0}};
            match_cnt_r <= {MW{1'b0}};
            err_run_r   <= {RW{1'b0}};
        end else begin
            shreg_r     <= shreg_n;
            seed_cnt_r  <= seed_cnt_n;
            match_cnt_r <= match_cnt_n;
            err_run_r   <= err_run_n;
        end
    end

    // Output next values; clear_errs wins over a same-cycle increment.
    always_comb begin
        locked_s    = (state_n == ST_LOCKED);
        bit_error_s = enable && (state_r == ST_LOCKED) && mismatch_s;
        lost_lock_s = bit_error_s && run_hit_s;
        if (clear_errs) begin
            err_count_s = {CNT_W{1'b0}};
        end else if (bit_error_s && (err_count_r != CNT_MAX)) begin
            err_count_s = err_count_r + CNT_W'(1);
        end else begin
            err_count_s = err_count_r;
        end
    end

    // Output registers.
    always_ff @(posedge clock) begin
        if (!reset_b) begin
            locked_r    <= 1'b0;
            bit_error_r <= 1'b0;
            lost_lock_r <= 1'b0;
            err_count_r <= {CNT_W{1'b0}};
        end else begin
            locked_r    <= locked_s;
            bit_error_r <= bit_error_s;
            lost_lock_r <= lost_lock_s;
            err_count_r <= err_count_s;
        end
    end

    assign locked    = locked_r;
    assign bit_error = bit_error_r;
    assign lost_lock = lost_lock_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker (WIDTH=3, LOCK_CNT=4, ERR_THRESH=4, CNT_W=3)
// against a behavioural model of the lock/verify/error rules.
module tb_prbs_checker;

    localparam int W  = 3;
    localparam int LC = 4;
    localparam int ET = 4;
    localparam int CW = 3;

    logic          clock = 1'b0;
    logic          reset_b = 1'b0;
    logic          enable = 1'b0;
    logic          data_in = 1'b0;
    logic          clear_errs = 1'b0;
    logic          locked;
    logic          bit_error;
    logic          lost_lock;
    logic [CW-1:0] err_count;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int m_state, m_ref, m_seed, m_match, m_run, m_err;
    bit m_locked, m_be, m_ll;

    // One period of the generator output for seed 001: 0010111
    logic [6:0] pat_v = 7'b0010111;
    int spos = 0;

    prbs_checker #(.WIDTH(W), .LOCK_CNT(LC), .ERR_THRESH(ET), .CNT_W(CW)) dut (
        .clock(clock), .reset_b(reset_b), .enable(enable), .data_in(data_in),
        .clear_errs(clear_errs), .locked(locked), .bit_error(bit_error),
        .lost_lock(lost_lock), .err_count(err_count)
    );

    always #5 clock = ~clock;

    task automatic next_bit(output bit b);
        b = pat_v[6 - spos];
        spos = (spos + 1) % 7;
    endtask

    task automatic model_reset();
        m_state = 0; m_ref = 0; m_seed = 0; m_match = 0; m_run = 0; m_err = 0;
        m_locked = 0; m_be = 0; m_ll = 0;
    endtask

    task automatic model_step(input bit en, input bit d, input bit clr);
        int p;
        m_be = 0;
        m_ll = 0;
        if (en) begin
            p = ((m_ref >> 2) ^ (m_ref >> 1)) & 1;
            case (m_state)
                0: begin
                    m_ref = ((m_ref << 1) | d) & 7;
                    m_seed++;
                    if (m_seed == W) begin
                        m_seed = 0;
                        if (m_ref != 0) m_state = 1;
                    end
                end
                1: begin
                    if (d == p) begin
                        m_match++;
                        if (m_match == LC) begin m_state = 2; m_match = 0; end
                    end else begin
                        m_state = 0; m_match = 0; m_seed = 0;
                    end
                    m_ref = ((m_ref << 1) | d) & 7;
                end
                default: begin
                    m_ref = ((m_ref << 1) | p) & 7;
                    if (d != p) begin
                        m_be = 1;
                        m_run++;
                        if (m_err < (1 << CW) - 1) m_err++;
                        if (m_run == ET) begin
                            m_state = 0; m_ll = 1; m_ref = 0; m_run = 0;
                        end
                    end else begin
                        m_run = 0;
                    end
                end
            endcase
        end
        if (clr) m_err = 0;
        m_locked = (m_state == 2);
    endtask

    task automatic step(input bit en, input bit d, input bit clr);
        reset_b = 1'b1; enable = en; data_in = d; clear_errs = clr;
        @(posedge clock);
        model_step(en, d, clr);
        #1;
    endtask

    task automatic do_reset();
        reset_b = 1'b0; enable = 1'($urandom_range(0, 1)); data_in = 1'($urandom_range(0, 1));
        clear_errs = 1'b0;
        @(posedge clock);
        model_reset();
        #1;
        reset_b = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
        do_reset();
        n_checks++;
        if ({locked, bit_error, lost_lock, err_count} !== {1'b0, 1'b0, 1'b0, 3'd0}) begin
            n_errors++;
            $display("FAIL reset_state: got l=%b be=%b ll=%b cnt=%0d, expected all zero",
                     locked, bit_error, lost_lock, err_count);
        end
    endtask

    task automatic test_lock();
        bit b;
        do_reset();
        spos = 0;
        for (int k = 0; k < 100; k++) begin
            next_bit(b);
            step(1'b1, b, 1'b0);
            n_checks++;
            if ({locked, bit_error, lost_lock, err_count} !== {m_locked, m_be, m_ll, CW'(m_err)}) begin
                n_errors++;
                $display("FAIL lock_model bit %0d: got l=%b be=%b ll=%b cnt=%0d, expected l=%b be=%b ll=%b cnt=%0d",
                         k, locked, bit_error, lost_lock, err_count, m_locked, m_be, m_ll, m_err);
            end
            n_checks++;
            if (locked !== (k >= 6)) begin
                n_errors++;
                $display("FAIL lock_point bit %0d: got locked=%b, expected %b", k, locked, (k >= 6));
            end
        end
        n_checks++;
        if (err_count !== 3'd0) begin
            n_errors++;
            $display("FAIL lock_clean_count: got %0d, expected 0", err_count);
        end
    endtask

    task automatic test_single_error();
        bit b;
        int idx, pulses;
        idx = $urandom_range(5, 20);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            next_bit(b);
            step(1'b1, b ^ (k == idx), 1'b0);
            pulses += bit_error;
            n_checks++;
            if ({locked, bit_error, lost_lock, err_count} !== {m_locked, m_be, m_ll, CW'(m_err)}) begin
                n_errors++;
                $display("FAIL single_model bit %0d: got l=%b be=%b ll=%b cnt=%0d, expected l=%b be=%b ll=%b cnt=%0d",
                         k, locked, bit_error, lost_lock, err_count, m_locked, m_be, m_ll, m_err);
            end
        end
        n_checks++;
        if (pulses != 1 || err_count !== 3'd1 || locked !== 1'b1) begin
            n_errors++;
            $display("FAIL single_error: got pulses=%0d cnt=%0d locked=%b, expected 1 1 1",
                     pulses, err_count, locked);
        end
    endtask

    task automatic test_loss();
        bit b;
        int relock;
        step(1'b0, 1'($urandom_range(0, 1)), 1'b1);
        n_checks++;
        if (err_count !== 3'd0 || bit_error !== 1'b0 || lost_lock !== 1'b0 || locked !== 1'b1) begin
            n_errors++;
            $display("FAIL clear_while_disabled: got cnt=%0d be=%b ll=%b l=%b, expected 0 0 0 1",
                     err_count, bit_error, lost_lock, locked);
        end
        for (int k = 0; k < ET; k++) begin
            next_bit(b);
            step(1'b1, ~b, 1'b0);
            n_checks++;
            if ({locked, bit_error, lost_lock} !== {(k != ET - 1), 1'b1, (k == ET - 1)}) begin
                n_errors++;
                $display("FAIL loss_run err %0d: got l=%b be=%b ll=%b, expected l=%b be=1 ll=%b",
                         k, locked, bit_error, lost_lock, (k != ET - 1), (k == ET - 1));
            end
        end
        n_checks++;
        if (err_count !== 3'd4) begin
            n_errors++;
            $display("FAIL loss_count: got %0d, expected 4", err_count);
        end
        relock = 0;
        for (int k = 0; k < 30 && !locked; k++) begin
            next_bit(b);
            step(1'b1, b, 1'b0);
            relock++;
            n_checks++;
            if (lost_lock !== 1'b0 || bit_error !== 1'b0) begin
                n_errors++;
                $display("FAIL relock_quiet bit %0d: got be=%b ll=%b, expected 0 0", k, bit_error, lost_lock);
            end
        end
        n_checks++;
        if (relock != W + LC || locked !== 1'b1) begin
            n_errors++;
            $display("FAIL relock_time: got %0d bits (locked=%b), expected %0d", relock, locked, W + LC);
        end
    endtask

    task automatic test_zero();
        do_reset();
        for (int k = 0; k < 40; k++) begin
            step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            n_checks++;
            if (locked !== 1'b0 || err_count !== 3'd0 || m_locked) begin
                n_errors++;
                $display("FAIL zero_stream cycle %0d: got l=%b cnt=%0d, expected 0 0", k, locked, err_count);
            end
        end
    endtask

    task automatic test_enable_gap();
        bit b;
        int en_bits, lock_at;
        do_reset();
        spos = 0;
        en_bits = 0;
        lock_at = -1;
        b = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c % 2 == 0) begin
                next_bit(b);
                step(1'b1, b, 1'b0);
                en_bits++;
            end else begin
                step(1'b0, b, 1'b0);
                n_checks++;
                if (bit_error !== 1'b0 || lost_lock !== 1'b0) begin
                    n_errors++;
                    $display("FAIL gap_pulses cycle %0d: got be=%b ll=%b, expected 0 0", c, bit_error, lost_lock);
                end
            end
            if (lock_at < 0 && locked === 1'b1) lock_at = en_bits;
            n_checks++;
            if ({locked, bit_error, lost_lock, err_count} !== {m_locked, m_be, m_ll, CW'(m_err)}) begin
                n_errors++;
                $display("FAIL gap_model cycle %0d: got l=%b be=%b ll=%b cnt=%0d, expected l=%b be=%b ll=%b cnt=%0d",
                         c, locked, bit_error, lost_lock, err_count, m_locked, m_be, m_ll, m_err);
            end
        end
        n_checks++;
        if (lock_at != W + LC) begin
            n_errors++;
            $display("FAIL gap_lock_point: got %0d enabled bits, expected %0d", lock_at, W + LC);
        end
        next_bit(b);
        step(1'b1, ~b, 1'b0);
        do_reset();
        n_checks++;
        if (locked !== 1'b0 || err_count !== 3'd0) begin
            n_errors++;
            $display("FAIL mid_lock_reset: got l=%b cnt=%0d, expected 0 0", locked, err_count);
        end
    endtask

    task automatic test_saturation();
        bit b, en, flip, clr;
        do_reset();
        spos = 0;
        for (int k = 0; k < W + LC; k++) begin
            next_bit(b);
            step(1'b1, b, 1'b0);
        end
        for (int e = 0; e < 10; e++) begin
            next_bit(b);
            step(1'b1, ~b, 1'b0);
            for (int g = $urandom_range(1, 3); g > 0; g--) begin
                next_bit(b);
                step(1'b1, b, 1'b0);
            end
            n_checks++;
            if (err_count !== CW'(m_err) || locked !== 1'b1) begin
                n_errors++;
                $display("FAIL sat_progress err %0d: got cnt=%0d l=%b, expected cnt=%0d l=1",
                         e, err_count, locked, m_err);
            end
        end
        n_checks++;
        if (err_count !== 3'd7) begin
            n_errors++;
            $display("FAIL saturate: got %0d, expected 7", err_count);
        end
        next_bit(b);
        step(1'b1, ~b, 1'b1);
        n_checks++;
        if (err_count !== 3'd0 || bit_error !== 1'b1) begin
            n_errors++;
            $display("FAIL clear_priority: got cnt=%0d be=%b, expected cnt=0 be=1", err_count, bit_error);
        end
        for (int k = 0; k < 80; k++) begin
            en   = ($urandom_range(0, 3) != 0);
            flip = ($urandom_range(0, 6) == 0);
            clr  = ($urandom_range(0, 9) == 0);
            if (en) next_bit(b);
            else    b = 1'($urandom_range(0, 1));
            step(en, b ^ flip, clr);
            n_checks++;
            if ({locked, bit_error, lost_lock, err_count} !== {m_locked, m_be, m_ll, CW'(m_err)}) begin
                n_errors++;
                $display("FAIL random_model cycle %0d: got l=%b be=%b ll=%b cnt=%0d, expected l=%b be=%b ll=%b cnt=%0d",
                         k, locked, bit_error, lost_lock, err_count, m_locked, m_be, m_ll, m_err);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock();
        test_single_error();
        test_loss();
        test_zero();
        test_enable_gap();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
